// File: rtl/legv8_pc_fetch_unit_pkg.sv
// ============================================================================
// Module      : legv8_pc_pkg
// Description : Shared types and constants for the LEGv8 PC / fetch stage.
//               FSM state encoding, PC step size and default reset address.
//               The FAULT state exists only when PC_ALIGN_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package legv8_pc_pkg;

  // Sequential instructions are one 32-bit word apart
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // Clears the byte-offset bits of a branch target
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2
`ifdef PC_ALIGN_CHECK_EN
    ,
    ST_FAULT = 2'd3
`endif
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/legv8_pc_fetch_unit_step_adder.sv
// ============================================================================
// Module      : pc_step_adder
// Description : 32-bit +PC_STEP incrementer, wraps modulo 2^32.
//               Used for both the fetch-PC advance and pc_plus4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_step_adder
  import legv8_pc_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] sum_o
);

  // Carry out of bit 31 is dropped, giving the required wrap-around
  assign sum_o = a_i + PC_STEP;

endmodule

`default_nettype wire

// File: rtl/legv8_pc_fetch_unit.sv
// ============================================================================
// Module      : legv8_pc_fetch_unit
// Description : LEGv8 program counter and instruction-fetch stage. Holds the
//               fetch PC, requests words from imem over req/ack, registers the
//               returned instruction with its PC, and honours stall and branch
//               redirect.
//               Optional: PC_ALIGN_CHECK_EN - misaligned branch targets trap
//               into a FAULT state left only by reset; when undefined the low
//               two target bits are cleared instead and fault is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module legv8_pc_fetch_unit
  import legv8_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;

  logic [31:0]  w_fetch_pc_inc;
  logic [31:0]  w_branch_pc;
  logic         w_imem_req;
  logic         w_fetch_ack;
  logic         w_consume;

  // A stalled live instruction suppresses the request so nothing is overwritten
  assign w_imem_req  = (state_q == ST_REQ) && !(stall && valid_q);
  // Acks are only honoured while a request is actually out
  assign w_fetch_ack = w_imem_req && imem_ack;
  assign w_consume   = valid_q && !stall;

`ifdef PC_ALIGN_CHECK_EN
  logic w_misaligned;
  assign w_misaligned = |branch_target[1:0];
  assign w_branch_pc  = branch_target;
`else
  assign w_branch_pc  = branch_target & PC_ALIGN_MASK;
`endif

  pc_step_adder u_fetch_inc (
    .a_i   (fetch_pc_q),
    .sum_o (w_fetch_pc_inc)
  );

  pc_step_adder u_pc_inc (
    .a_i   (pc_q),
    .sum_o (pc_plus4)
  );

  // Fetch FSM: priority reset > branch > ack > stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_REQ, ST_HOLD: begin
          if (branch_taken) begin
            // Redirect squashes the current word and any same-cycle ack
            valid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (w_misaligned) begin
              state_q <= ST_FAULT;
            end else begin
              fetch_pc_q <= w_branch_pc;
              state_q    <= ST_REQ;
            end
`else
            fetch_pc_q <= w_branch_pc;
            state_q    <= ST_REQ;
`endif
          end else if (state_q == ST_IDLE) begin
            state_q <= ST_REQ;
          end else if (state_q == ST_HOLD) begin
            // Leaving HOLD consumes the held word; no request was out to refill it
            if (!stall) begin
              state_q <= ST_REQ;
              valid_q <= 1'b0;
            end
          end else begin
            if (w_fetch_ack) begin
              instr_q    <= imem_data;
              pc_q       <= fetch_pc_q;
              valid_q    <= 1'b1;
              fetch_pc_q <= w_fetch_pc_inc;
            end else if (stall && valid_q) begin
              state_q <= ST_HOLD;
            end else if (w_consume) begin
              valid_q <= 1'b0;
            end
          end
        end
`ifdef PC_ALIGN_CHECK_EN
        ST_FAULT: begin
          valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;

`ifdef PC_ALIGN_CHECK_EN
  assign fault = (state_q == ST_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_legv8_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_legv8_pc_fetch_unit
// Description : Self-checking bench for legv8_pc_fetch_unit. Two instances
//               share stimulus: one at the default reset PC and one reset
//               near the top of the address space to exercise wrap-around.
//               Honours PC_ALIGN_CHECK_EN for the misaligned-branch case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_legv8_pc_fetch_unit;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ack;

  logic [1:0]  req_w;
  logic [31:0] addr_w  [2];
  logic [31:0] data_w  [2];
  logic [1:0]  valid_w;
  logic [31:0] instr_w [2];
  logic [31:0] pc_w    [2];
  logic [31:0] pcp4_w  [2];
  logic [1:0]  fault_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory content: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) + 32'h1357_9BDF;
  endfunction

  assign data_w[0] = mem_word(addr_w[0]);
  assign data_w[1] = mem_word(addr_w[1]);

  legv8_pc_fetch_unit u_dut0 (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req_w[0]), .imem_addr(addr_w[0]), .imem_ack(imem_ack),
    .imem_data(data_w[0]), .instr_valid(valid_w[0]), .instr(instr_w[0]),
    .pc(pc_w[0]), .pc_plus4(pcp4_w[0]), .fault(fault_w[0])
  );

  legv8_pc_fetch_unit #(.RESET_PC(WRAP_PC)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req_w[1]), .imem_addr(addr_w[1]), .imem_ack(imem_ack),
    .imem_data(data_w[1]), .instr_valid(valid_w[1]), .instr(instr_w[1]),
    .pc(pc_w[1]), .pc_plus4(pcp4_w[1]), .fault(fault_w[1])
  );

  task automatic chk(input string name, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // live: past the post-reset idle cycle; hold: parked behind a stall
  logic [31:0] m_fpc   [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_instr [2];
  bit          m_valid [2];
  bit          m_live  [2];
  bit          m_hold  [2];
  bit          m_fault [2];
  bit          m_ready = 1'b0;

  function automatic bit exp_req(input int k);
    return m_live[k] && !m_hold[k] && !m_fault[k] && !(stall && m_valid[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_fpc[k]   <= (k == 0) ? 32'h0 : WRAP_PC;
        m_pc[k]    <= (k == 0) ? 32'h0 : WRAP_PC;
        m_instr[k] <= 32'h0;
        m_valid[k] <= 1'b0;
        m_live[k]  <= 1'b0;
        m_hold[k]  <= 1'b0;
        m_fault[k] <= 1'b0;
      end else if (m_fault[k]) begin
        m_valid[k] <= 1'b0;
      end else if (branch_taken) begin
        m_valid[k] <= 1'b0;
        m_hold[k]  <= 1'b0;
        m_live[k]  <= 1'b1;
        if (CHECK_EN && (branch_target[1:0] != 2'b00))
          m_fault[k] <= 1'b1;
        else
          m_fpc[k] <= {branch_target[31:2], 2'b00};
      end else if (!m_live[k]) begin
        m_live[k] <= 1'b1;
      end else if (m_hold[k]) begin
        if (!stall) begin
          m_hold[k]  <= 1'b0;
          m_valid[k] <= 1'b0;
        end
      end else if (exp_req(k) && imem_ack) begin
        m_instr[k] <= mem_word(m_fpc[k]);
        m_pc[k]    <= m_fpc[k];
        m_valid[k] <= 1'b1;
        m_fpc[k]   <= m_fpc[k] + 32'd4;
      end else if (stall && m_valid[k]) begin
        m_hold[k] <= 1'b1;
      end else if (m_valid[k]) begin
        m_valid[k] <= 1'b0;
      end
    end
    if (reset) m_ready <= 1'b1;
  end

  // Compare every output of both instances on the falling edge
  always @(negedge clk) begin
    if (m_ready) begin
      for (int k = 0; k < 2; k++) begin
        chk("imem_req",    k, {31'h0, req_w[k]},   {31'h0, exp_req(k)});
        chk("imem_addr",   k, addr_w[k],           m_fpc[k]);
        chk("instr_valid", k, {31'h0, valid_w[k]}, {31'h0, m_valid[k]});
        chk("instr",       k, instr_w[k],          m_instr[k]);
        chk("pc",          k, pc_w[k],             m_pc[k]);
        chk("pc_plus4",    k, pcp4_w[k],           m_pc[k] + 32'd4);
        chk("fault",       k, {31'h0, fault_w[k]}, {31'h0, m_fault[k]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          st;
    bit          ak;
    bit          bt;
    logic [31:0] tg;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{0, 1, 0, 32'h0};
    tbl[1]  = '{0, 1, 0, 32'h0};
    tbl[2]  = '{1, 1, 0, 32'h0};
    tbl[3]  = '{1, 1, 0, 32'h0};
    tbl[4]  = '{1, 1, 1, 32'h200};
    tbl[5]  = '{1, 1, 0, 32'h0};
    tbl[6]  = '{1, 0, 0, 32'h0};
    tbl[7]  = '{0, 1, 0, 32'h0};
    tbl[8]  = '{0, 0, 0, 32'h0};
    tbl[9]  = '{0, 1, 0, 32'h0};
    tbl[10] = '{0, 1, 1, 32'h3FC};
    tbl[11] = '{0, 1, 0, 32'h0};
    tbl[12] = '{0, 1, 0, 32'h0};
    tbl[13] = '{1, 0, 0, 32'h0};
    tbl[14] = '{1, 0, 1, 32'h40};
    tbl[15] = '{0, 1, 0, 32'h0};

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ack = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 0, {31'h0, valid_w[0]}, 32'h0);
    chk("rst_req",   0, {31'h0, req_w[0]},   32'h0);
    chk("rst_pc",    0, pc_w[0],             32'h0);
    chk("rst_instr", 0, instr_w[0],          32'h0);
    chk("rst_fault", 0, {31'h0, fault_w[0]}, 32'h0);
    chk("rst_pc",    1, pc_w[1],             32'hFFFF_FFF8);

    // cycle 0: IDLE, stray ack must be ignored
    reset = 1'b0; imem_ack = 1'b1;
    cyc();  // cycle 1
    chk("c1_req",  0, {31'h0, req_w[0]}, 32'h1);
    chk("c1_addr", 0, addr_w[0],         32'h0);
    chk("c1_addr", 1, addr_w[1],         32'hFFFF_FFF8);
    cyc();  // cycle 2
    chk("c2_valid", 0, {31'h0, valid_w[0]}, 32'h1);
    chk("c2_pc",    0, pc_w[0],             32'h0);
    chk("c2_instr", 0, instr_w[0],          32'h1357_9BDF);
    chk("c2_addr",  0, addr_w[0],           32'h4);
    chk("c2_pc",    1, pc_w[1],             32'hFFFF_FFF8);
    cyc();  // cycle 3
    chk("c3_pc",   0, pc_w[0],   32'h4);
    chk("c3_pc",   1, pc_w[1],   32'hFFFF_FFFC);
    chk("c3_pcp4", 1, pcp4_w[1], 32'h0);
    cyc();  // cycle 4
    chk("c4_pc",   0, pc_w[0],   32'h8);
    chk("c4_pc",   1, pc_w[1],   32'h0);
    chk("c4_addr", 0, addr_w[0], 32'hC);

    // stall for three cycles with pc=8
    stall = 1'b1;
    cyc();
    chk("hold_req",   0, {31'h0, req_w[0]},   32'h0);
    chk("hold_pc",    0, pc_w[0],             32'h8);
    chk("hold_instr", 0, instr_w[0],          32'h135F_9BF7);
    chk("hold_valid", 0, {31'h0, valid_w[0]}, 32'h1);
    cyc();
    cyc();
    chk("hold3_pc", 0, pc_w[0], 32'h8);
    stall = 1'b0;
    cyc();
    chk("rel_valid", 0, {31'h0, valid_w[0]}, 32'h0);
    chk("rel_addr",  0, addr_w[0],           32'hC);
    cyc();
    chk("rel_pc", 0, pc_w[0], 32'hC);

    // branch with a simultaneous ack
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    cyc();
    branch_taken = 1'b0;
    chk("br_valid", 0, {31'h0, valid_w[0]}, 32'h0);
    chk("br_addr",  0, addr_w[0],           32'h100);
    chk("br_pc",    0, pc_w[0],             32'hC);
    cyc();
    chk("br_pc2", 0, pc_w[0], 32'h100);

    // misaligned branch target
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    cyc();
    branch_taken = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_fault", 0, {31'h0, fault_w[0]}, 32'h1);
    chk("mis_req",   0, {31'h0, req_w[0]},   32'h0);
    chk("mis_valid", 0, {31'h0, valid_w[0]}, 32'h0);
    repeat (3) cyc();
    chk("mis_sticky", 0, {31'h0, fault_w[0]}, 32'h1);
`else
    chk("mis_addr",  0, addr_w[0],           32'h100);
    chk("mis_fault", 0, {31'h0, fault_w[0]}, 32'h0);
    repeat (3) cyc();
    chk("mis_fault2", 0, {31'h0, fault_w[0]}, 32'h0);
`endif

    // reset while a request is outstanding
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rr_fault", 0, {31'h0, fault_w[0]}, 32'h0);
    cyc();
    cyc();
    cyc();
    imem_ack = 1'b0;
    cyc();
    cyc();
    chk("wait_req",   0, {31'h0, req_w[0]},   32'h1);
    chk("wait_valid", 0, {31'h0, valid_w[0]}, 32'h0);
    chk("wait_pc",    0, pc_w[0],             32'h4);
    chk("wait_addr",  0, addr_w[0],           32'h8);
    reset = 1'b1;
    cyc();
    chk("mr_req",   0, {31'h0, req_w[0]},   32'h0);
    chk("mr_valid", 0, {31'h0, valid_w[0]}, 32'h0);
    chk("mr_pc",    0, pc_w[0],             32'h0);
    chk("mr_pc",    1, pc_w[1],             32'hFFFF_FFF8);
    reset = 1'b0;
    cyc();
    chk("mr_req2", 0, {31'h0, req_w[0]}, 32'h1);

    // mixed table: stall/ack/branch interactions, checked by the model
    for (int i = 0; i < 16; i++) begin
      stall         = tbl[i].st;
      imem_ack      = tbl[i].ak;
      branch_taken  = tbl[i].bt;
      branch_target = tbl[i].tg;
      cyc();
    end
    stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
    repeat (2) cyc();
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
